// File: rtl/pipe_hazard_ctrl.sv
// Purpose : hazard unit for a 5-stage pipeline. It covers forwarding selection, the load-use
//           stall, multi-cycle (mult/div) occupancy of EX and the branch flush of IF/ID.
// Latency : forwarding, stall and flush outputs are combinational from ID fields and the shadow
//           EX/MEM records. The records, FSM and stall counter update on each rising clk edge.
// Backpressure: wpcir=0 freezes PC and IF/ID and bubble=1 injects a nop into ID/EX. A load-use
//           hazard stalls for one cycle and an md op stalls for MD_LAT-1 cycles.
// Ports   : clk, clrn (sync active-low reset); ID fields id_rs/id_rt/id_use_rs/id_use_rt/id_rd/
//           id_wreg/id_m2reg/id_md/id_branch_taken; outputs wpcir, reset_ir, bubble, fwda, fwdb,
//           md_busy and stall_cnt (saturating count of stalled cycles).
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4  // total EX occupancy of a mult/div op, legal range 2..16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_wreg,
  input  logic        id_m2reg,
  input  logic        id_md,
  input  logic        id_branch_taken,
  output logic        wpcir,
  output logic        reset_ir,
  output logic        bubble,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Shadow copies of the destination info carried by the EX and MEM stages.
  logic       ex_wreg, ex_m2reg;
  logic [4:0] ex_rd;
  logic       mem_wreg, mem_m2reg;
  logic [4:0] mem_rd;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use;

  // Register 0 is hard-wired zero, so a write to it never produces a hit.
  assign ex_hit_rs  = ex_wreg  && (ex_rd  != 5'd0) && (ex_rd  == id_rs);
  assign ex_hit_rt  = ex_wreg  && (ex_rd  != 5'd0) && (ex_rd  == id_rt);
  assign mem_hit_rs = mem_wreg && (mem_rd != 5'd0) && (mem_rd == id_rs);
  assign mem_hit_rt = mem_wreg && (mem_rd != 5'd0) && (mem_rd == id_rt);

  // A load still in EX has no data yet, so a consumer in ID must wait one cycle.
  assign load_use = ex_wreg && ex_m2reg && (ex_rd != 5'd0) &&
                    ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));

  // The youngest ALU result wins. A load in EX cannot forward, so the selection falls through to MEM.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_ld,
                                         input logic mem_hit, input logic mem_ld);
    if (ex_hit && !ex_ld)       fwd_sel = 2'b01;
    else if (mem_hit && !mem_ld) fwd_sel = 2'b10;
    else if (mem_hit && mem_ld)  fwd_sel = 2'b11;
    else                         fwd_sel = 2'b00;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wpcir     = 1'b1;
    reset_ir  = 1'b0;
    bubble    = 1'b0;
    md_busy   = 1'b0;
    fwda      = fwd_sel(ex_hit_rs, ex_m2reg, mem_hit_rs, mem_m2reg);
    fwdb      = fwd_sel(ex_hit_rt, ex_m2reg, mem_hit_rt, mem_m2reg);
    if (!clrn) begin
      // While in reset, flush both front-end registers and select no forwarding.
      reset_ir  = 1'b1;
      bubble    = 1'b1;
      fwda      = 2'b00;
      fwdb      = 2'b00;
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        MD_BUSY: begin
          md_busy = 1'b1;
          wpcir   = 1'b0;
          bubble  = 1'b1;
          if (cnt == 4'd0) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 4'd1;
        end
        default: begin
          if (load_use) begin
            // The stalled instruction is re-presented next cycle, so flush and md entry wait for it.
            wpcir  = 1'b0;
            bubble = 1'b1;
          end else begin
            reset_ir = id_branch_taken;
            if (id_md) begin
              // The md op issues now. The cycles spent in MD_BUSY run from cnt=MD_LAT-2 down to 0.
              state_nxt = MD_BUSY;
              cnt_nxt   = 4'(MD_LAT - 2);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_rd     <= 5'd0;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
      mem_rd    <= 5'd0;
      stall_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_wreg  <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      mem_rd    <= ex_rd;
      if (bubble) begin
        ex_wreg  <= 1'b0;
        ex_m2reg <= 1'b0;
        ex_rd    <= 5'd0;
      end else begin
        ex_wreg  <= id_wreg;
        ex_m2reg <= id_m2reg;
        ex_rd    <= id_rd;
      end
      if (!wpcir && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
